rvfi_rollback_filter: RTL and testbench

- Sits directly upstream of the per-channel instruction checker; one instance per retire channel.
- Delays each retired RVFI record by a fixed HOLD cycles and squashes records later cancelled by rvfi_rollback, so the checker only sees committed instructions and can run against rollback-capable cores.
- Tracks retire-order continuity and flags protocol errors.
- Generates the checker's `check` strobe for one selected order number.

---
 rtl/rvfi_rollback_filter_if.sv | 38 +++
 rtl/rvfi_rollback_filter.sv | 115 +++++++++++
 tb/tb_rvfi_rollback_filter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/rvfi_rollback_filter_if.sv
// Retire-channel bundle between the RVFI source, the rollback filter and the checker.
// The slave modport is the filter's view; the master modport belongs to whatever drives the retire stream.
interface rvfi_rollback_filter_if #(
    parameter int HOLD      = 4,
    parameter int ORDER_W   = 64,
    parameter int PAYLOAD_W = 512
);
    localparam int CNT_W = $clog2(HOLD + 1);

    logic                 in_valid;
    logic [ORDER_W-1:0]   in_order;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 rollback_valid;
    logic [ORDER_W-1:0]   rollback_order;
    logic [ORDER_W-1:0]   check_order;

    logic                 out_valid;
    logic [ORDER_W-1:0]   out_order;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 out_check;
    logic [CNT_W-1:0]     live_count;
    logic                 seq_err;
    logic                 late_rb_err;

    modport slave (
        input  in_valid, in_order, in_payload,
        input  rollback_valid, rollback_order, check_order,
        output out_valid, out_order, out_payload, out_check,
        output live_count, seq_err, late_rb_err
    );

    modport master (
        output in_valid, in_order, in_payload,
        output rollback_valid, rollback_order, check_order,
        input  out_valid, out_order, out_payload, out_check,
        input  live_count, seq_err, late_rb_err
    );
endinterface

// File: rtl/rvfi_rollback_filter.sv
// Holds each retired RVFI record for HOLD cycles and squashes the ones a later rollback cancels,
// so the downstream checker only sees committed instructions. Also tracks retire-order continuity.
module rvfi_rollback_filter #(
    parameter int HOLD      = 4,
    parameter int ORDER_W   = 64,
    parameter int PAYLOAD_W = 512
) (
    input  logic                   clock,
    input  logic                   reset,
    rvfi_rollback_filter_if.slave  bus
);
    localparam int CNT_W = $clog2(HOLD + 1);

    // Delay line: index 0 takes the incoming record, index HOLD-1 drives the outputs.
    logic                 live_q    [HOLD];
    logic                 live_d    [HOLD];
    logic [ORDER_W-1:0]   order_q   [HOLD];
    logic [ORDER_W-1:0]   order_d   [HOLD];
    logic [PAYLOAD_W-1:0] payload_q [HOLD];
    logic [PAYLOAD_W-1:0] payload_d [HOLD];

    logic [ORDER_W-1:0] expected_q,  expected_d;
    logic [ORDER_W-1:0] committed_q, committed_d;
    logic [ORDER_W-1:0] eff_expected;
    logic [CNT_W-1:0]   live_count_q, live_count_d;
    logic               seq_err_q,    seq_err_d;
    logic               late_rb_err_q, late_rb_err_d;

    // NOTE: every signal assigned here gets a default first, so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        live_d[0]    = bus.in_valid;
        order_d[0]   = bus.in_order;
        payload_d[0] = bus.in_payload;
        for (int k = 1; k < HOLD; k++) begin
            live_d[k]    = live_q[k-1] &&
                           !(bus.rollback_valid && (order_q[k-1] >= bus.rollback_order));
            order_d[k]   = order_q[k-1];
            payload_d[k] = payload_q[k-1];
        end
    end

    // Continuity tracking: a rollback rewinds the retire stream to rollback_order.
    always_comb begin
        eff_expected = bus.rollback_valid ? bus.rollback_order : expected_q;
        expected_d   = bus.in_valid ? (bus.in_order + ORDER_W'(1)) : eff_expected;

        seq_err_d = seq_err_q;
        if (bus.in_valid && (bus.in_order != eff_expected)) begin
            seq_err_d = 1'b1;
        end
        if (bus.rollback_valid && (bus.rollback_order > expected_q)) begin
            seq_err_d = 1'b1;
        end

        late_rb_err_d = late_rb_err_q;
        if (bus.rollback_valid && (bus.rollback_order < committed_q)) begin
            late_rb_err_d = 1'b1;
        end

        committed_d = committed_q;
        if (live_d[HOLD-1]) begin
            committed_d = order_d[HOLD-1] + ORDER_W'(1);
        end
    end

    always_comb begin
        live_count_d = '0;
        for (int k = 0; k < HOLD; k++) begin
            live_count_d = live_count_d + CNT_W'(live_d[k]);
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < HOLD; k++) begin
                live_q[k] <= 1'b0;
            end
            expected_q    <= '0;
            committed_q   <= '0;
            live_count_q  <= '0;
            seq_err_q     <= 1'b0;
            late_rb_err_q <= 1'b0;
        end else begin
            for (int k = 0; k < HOLD; k++) begin
                live_q[k] <= live_d[k];
            end
            expected_q    <= expected_d;
            committed_q   <= committed_d;
            live_count_q  <= live_count_d;
            seq_err_q     <= seq_err_d;
            late_rb_err_q <= late_rb_err_d;
        end
    end

    // NOTE: the wide order/payload storage is deliberately left unreset; the live bits
    // qualify it and the outputs below are masked while the output stage is empty.
    always_ff @(posedge clock) begin
        for (int k = 0; k < HOLD; k++) begin
            order_q[k]   <= order_d[k];
            payload_q[k] <= payload_d[k];
        end
    end

    assign bus.out_valid   = live_q[HOLD-1];
    assign bus.out_order   = live_q[HOLD-1] ? order_q[HOLD-1]   : '0;
    assign bus.out_payload = live_q[HOLD-1] ? payload_q[HOLD-1] : '0;
    assign bus.out_check   = live_q[HOLD-1] && (order_q[HOLD-1] == bus.check_order);
    assign bus.live_count  = live_count_q;
    assign bus.seq_err     = seq_err_q;
    assign bus.late_rb_err = late_rb_err_q;

endmodule

// File: tb/tb_rvfi_rollback_filter.sv
// Directed bench for rvfi_rollback_filter with HOLD=4: latency, rollback squashing,
// order-continuity errors, check strobe and asynchronous reset.
module tb_rvfi_rollback_filter;
    localparam int HOLD      = 4;
    localparam int ORDER_W   = 64;
    localparam int PAYLOAD_W = 512;

    logic clock;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    rvfi_rollback_filter_if #(.HOLD(HOLD), .ORDER_W(ORDER_W), .PAYLOAD_W(PAYLOAD_W)) bus ();

    rvfi_rollback_filter #(.HOLD(HOLD), .ORDER_W(ORDER_W), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [PAYLOAD_W-1:0] pay(input int o);
        logic [31:0] w;
        w = 32'(o) ^ 32'hC0DE_5A00;
        return {16{w}};
    endfunction

    task automatic chk(input string tag, input logic [PAYLOAD_W-1:0] obs, input logic [PAYLOAD_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // exp_ord < 0 means the output stage must be empty this cycle.
    task automatic chk_out(input string tag, input int c, input int exp_ord);
        chk($sformatf("%s c%0d valid", tag, c), PAYLOAD_W'(bus.out_valid), PAYLOAD_W'(exp_ord >= 0));
        chk($sformatf("%s c%0d order", tag, c), PAYLOAD_W'(bus.out_order),
            (exp_ord >= 0) ? PAYLOAD_W'(exp_ord) : '0);
        chk($sformatf("%s c%0d payload", tag, c), bus.out_payload,
            (exp_ord >= 0) ? pay(exp_ord) : '0);
    endtask

    task automatic drive(input logic v, input int o, input logic rbv, input int rbo);
        bus.in_valid       = v;
        bus.in_order       = ORDER_W'(o);
        bus.in_payload     = pay(o);
        bus.rollback_valid = rbv;
        bus.rollback_order = ORDER_W'(rbo);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Leaves the bench 1 ns after an edge with reset released: that instant is cycle 0.
    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 0, 1'b0, 0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int exp_ord;
        int n;

        reset = 1'b0;
        bus.check_order = ORDER_W'(3);
        drive(1'b0, 0, 1'b0, 0);
        #1 reset = 1'b1;
        #1;
        chk("reset out_valid",   PAYLOAD_W'(bus.out_valid),   '0);
        chk("reset out_order",   PAYLOAD_W'(bus.out_order),   '0);
        chk("reset out_payload", bus.out_payload,             '0);
        chk("reset live_count",  PAYLOAD_W'(bus.live_count),  '0);
        chk("reset seq_err",     PAYLOAD_W'(bus.seq_err),     '0);
        chk("reset late_rb_err", PAYLOAD_W'(bus.late_rb_err), '0);

        // Back-to-back orders 0..5; check strobe only when order 3 is on the outputs.
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            exp_ord = (c >= 4 && c <= 9) ? c - 4 : -1;
            chk_out("b2b", c, exp_ord);
            chk($sformatf("b2b c%0d out_check", c), PAYLOAD_W'(bus.out_check), PAYLOAD_W'(c == 7));
            n = 0;
            for (int j = c - 4; j <= c - 1; j++) if (j >= 0 && j <= 5) n++;
            chk($sformatf("b2b c%0d live_count", c), PAYLOAD_W'(bus.live_count), PAYLOAD_W'(n));
            if (c <= 5) drive(1'b1, c, 1'b0, 0);
            else        drive(1'b0, 0, 1'b0, 0);
            tick();
        end
        chk("b2b seq_err",     PAYLOAD_W'(bus.seq_err),     '0);
        chk("b2b late_rb_err", PAYLOAD_W'(bus.late_rb_err), '0);

        // Rollback to 2 in cycle 5 with the re-executed order 2 pushed alongside.
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            case (c)
                4: exp_ord = 0;
                5: exp_ord = 1;
                9: exp_ord = 2;
                default: exp_ord = -1;
            endcase
            chk_out("rb2", c, exp_ord);
            if (c <= 3)      drive(1'b1, c, 1'b0, 0);
            else if (c == 5) drive(1'b1, 2, 1'b1, 2);
            else             drive(1'b0, 0, 1'b0, 0);
            tick();
        end
        chk("rb2 seq_err",     PAYLOAD_W'(bus.seq_err),     '0);
        chk("rb2 late_rb_err", PAYLOAD_W'(bus.late_rb_err), '0);

        // Rollback to 1 after order 1 is already on the outputs: late, not retracted.
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            case (c)
                4: exp_ord = 0;
                5: exp_ord = 1;
                9: exp_ord = 1;
                default: exp_ord = -1;
            endcase
            chk_out("rb1", c, exp_ord);
            chk($sformatf("rb1 c%0d late_rb_err", c), PAYLOAD_W'(bus.late_rb_err), PAYLOAD_W'(c >= 6));
            if (c <= 3)      drive(1'b1, c, 1'b0, 0);
            else if (c == 5) drive(1'b1, 1, 1'b1, 1);
            else             drive(1'b0, 0, 1'b0, 0);
            tick();
        end

        // Order gap 0 -> 2: flagged, both records still emitted.
        do_reset();
        for (int c = 0; c <= 6; c++) begin
            case (c)
                4: exp_ord = 0;
                5: exp_ord = 2;
                default: exp_ord = -1;
            endcase
            chk_out("gap", c, exp_ord);
            chk($sformatf("gap c%0d seq_err", c), PAYLOAD_W'(bus.seq_err), PAYLOAD_W'(c >= 2));
            if (c == 0)      drive(1'b1, 0, 1'b0, 0);
            else if (c == 1) drive(1'b1, 2, 1'b0, 0);
            else             drive(1'b0, 0, 1'b0, 0);
            tick();
        end

        // Rollback to 7 while expected is 3: rollback ahead of the retire stream.
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            chk($sformatf("ahead c%0d seq_err", c), PAYLOAD_W'(bus.seq_err), PAYLOAD_W'(c >= 4));
            if (c <= 2)      drive(1'b1, c, 1'b0, 0);
            else if (c == 3) drive(1'b0, 0, 1'b1, 7);
            else             drive(1'b0, 0, 1'b0, 0);
            tick();
        end
        chk_out("ahead", 5, 1);
        chk("ahead late_rb_err", PAYLOAD_W'(bus.late_rb_err), '0);

        // Order 3 killed by a rollback: out_check must never fire.
        do_reset();
        for (int c = 0; c <= 9; c++) begin
            exp_ord = (c >= 4 && c <= 6) ? c - 4 : -1;
            chk_out("kill3", c, exp_ord);
            chk($sformatf("kill3 c%0d out_check", c), PAYLOAD_W'(bus.out_check), '0);
            if (c <= 3)      drive(1'b1, c, 1'b0, 0);
            else if (c == 4) drive(1'b0, 0, 1'b1, 3);
            else             drive(1'b0, 0, 1'b0, 0);
            tick();
        end
        chk("kill3 seq_err", PAYLOAD_W'(bus.seq_err), '0);

        // Asynchronous reset mid-cycle with a full pipeline and a sticky error raised.
        do_reset();
        for (int c = 0; c <= 3; c++) begin
            drive(1'b1, (c == 0) ? 0 : c + 1, 1'b0, 0);
            tick();
        end
        drive(1'b0, 0, 1'b0, 0);
        chk("pre-arst out_valid",  PAYLOAD_W'(bus.out_valid),  PAYLOAD_W'(1));
        chk("pre-arst live_count", PAYLOAD_W'(bus.live_count), PAYLOAD_W'(4));
        chk("pre-arst seq_err",    PAYLOAD_W'(bus.seq_err),    PAYLOAD_W'(1));
        #2 reset = 1'b1;
        #1;
        chk("arst out_valid",   PAYLOAD_W'(bus.out_valid),   '0);
        chk("arst out_order",   PAYLOAD_W'(bus.out_order),   '0);
        chk("arst out_payload", bus.out_payload,             '0);
        chk("arst live_count",  PAYLOAD_W'(bus.live_count),  '0);
        chk("arst seq_err",     PAYLOAD_W'(bus.seq_err),     '0);
        tick();
        reset = 1'b0;
        drive(1'b1, 0, 1'b0, 0);
        tick();
        drive(1'b0, 0, 1'b0, 0);
        chk("post-arst seq_err",    PAYLOAD_W'(bus.seq_err),    '0);
        chk("post-arst live_count", PAYLOAD_W'(bus.live_count), PAYLOAD_W'(1));
        tick();
        tick();
        tick();
        chk_out("post-arst", 4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
